ara_perf_window_ctrl: RTL and testbench

//  Sequences the vector-runtime measurement window for Ara and owns its counters.
//  A software enable arms the window; the first dispatched vector instruction opens it.

---
 rtl/ara_perf_window_ctrl.sv | 123 ++++++++++++
 tb/tb_ara_perf_window_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ara_perf_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ara_perf_window_ctrl
// Brief    : Arms, runs and drains the Ara vector-runtime measurement window;
//            owns the saturating live counters and their snapshot buffers.
// Revision : 1.0 - initial release
// ============================================================================
module ara_perf_window_ctrl #(
  parameter int unsigned NrEvents = 3,
  parameter int unsigned CntWidth = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         sw_en_i,
  input  logic                         clear_i,
  input  logic                         vinsn_valid_i,
  input  logic                         ara_idle_i,
  input  logic [NrEvents-1:0]          event_i,
  output logic [1:0]                   state_o,
  output logic [CntWidth-1:0]          runtime_o,
  output logic [NrEvents*CntWidth-1:0] event_cnt_o,
  output logic                         snap_valid_o,
  output logic                         overflow_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [CntWidth-1:0] C_CNT_MAX = '1;
  localparam logic [CntWidth-1:0] C_CNT_ONE = CntWidth'(1);

  state_e                r_state;
  state_e                w_state_next;
  logic [CntWidth-1:0]   r_runtime;
  logic [CntWidth-1:0]   r_event_cnt [NrEvents];
  logic [CntWidth-1:0]   r_runtime_buf;
  logic [CntWidth-1:0]   r_event_buf [NrEvents];
  logic                  r_pending;
  logic                  r_snap_valid;
  logic                  r_overflow;
  logic                  w_counting;
  logic                  w_fire;
  logic                  w_ovf_set;
  logic [NrEvents-1:0]   w_evt_sat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (sw_en_i && vinsn_valid_i) w_state_next = RUN;
      RUN:     if (!sw_en_i) w_state_next = DRAIN;
      DRAIN: begin
        // Re-enabling software takes precedence over the drain completing.
        if (sw_en_i)                              w_state_next = RUN;
        else if (ara_idle_i && !vinsn_valid_i)    w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_counting = (r_state == RUN) || (r_state == DRAIN);
  assign w_fire     = r_pending && ara_idle_i && !vinsn_valid_i;

  for (genvar k = 0; k < NrEvents; k++) begin : g_evt
    assign w_evt_sat[k] = event_i[k] && (r_event_cnt[k] == C_CNT_MAX);
    assign event_cnt_o[k*CntWidth +: CntWidth] = r_event_buf[k];
  end

  assign w_ovf_set = w_counting && ((r_runtime == C_CNT_MAX) || (|w_evt_sat));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_runtime     <= '0;
      r_runtime_buf <= '0;
      r_pending     <= 1'b0;
      r_snap_valid  <= 1'b0;
      r_overflow    <= 1'b0;
      for (int k = 0; k < int'(NrEvents); k++) begin
        r_event_cnt[k] <= '0;
        r_event_buf[k] <= '0;
      end
    end else if (clear_i) begin
      r_runtime     <= '0;
      r_runtime_buf <= '0;
      r_pending     <= 1'b0;
      r_snap_valid  <= 1'b0;
      r_overflow    <= 1'b0;
      for (int k = 0; k < int'(NrEvents); k++) begin
        r_event_cnt[k] <= '0;
        r_event_buf[k] <= '0;
      end
    end else begin
      if (w_counting && (r_runtime != C_CNT_MAX)) r_runtime <= r_runtime + C_CNT_ONE;
      for (int k = 0; k < int'(NrEvents); k++) begin
        if (w_counting && event_i[k] && (r_event_cnt[k] != C_CNT_MAX))
          r_event_cnt[k] <= r_event_cnt[k] + C_CNT_ONE;
      end
      if (w_ovf_set) r_overflow <= 1'b1;
      // A new request keeps the snapshot armed even if Ara looks idle this cycle.
      if (vinsn_valid_i) r_pending <= 1'b1;
      else if (w_fire)   r_pending <= 1'b0;
      r_snap_valid <= w_fire;
      if (w_fire) begin
        r_runtime_buf <= r_runtime;
        for (int k = 0; k < int'(NrEvents); k++) r_event_buf[k] <= r_event_cnt[k];
      end
    end
  end

  assign state_o      = r_state;
  assign runtime_o    = r_runtime_buf;
  assign snap_valid_o = r_snap_valid;
  assign overflow_o   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ara_perf_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ara_perf_window_ctrl
// Brief    : Directed self-checking bench for ara_perf_window_ctrl (64-bit and
//            4-bit counter instances driven from the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ara_perf_window_ctrl;

  logic         clk;
  logic         rst_n;
  logic         sw_en;
  logic         clear;
  logic         vinsn;
  logic         idle;
  logic [2:0]   ev;

  logic [1:0]   s64;
  logic [63:0]  rt64;
  logic [191:0] ec64;
  logic         sv64;
  logic         of64;

  logic [1:0]   s4;
  logic [3:0]   rt4;
  logic [11:0]  ec4;
  logic         sv4;
  logic         of4;

  int n_tests = 0;
  int n_fail  = 0;

  ara_perf_window_ctrl #(.NrEvents(3), .CntWidth(64)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .sw_en_i(sw_en), .clear_i(clear),
    .vinsn_valid_i(vinsn), .ara_idle_i(idle), .event_i(ev),
    .state_o(s64), .runtime_o(rt64), .event_cnt_o(ec64),
    .snap_valid_o(sv64), .overflow_o(of64)
  );

  ara_perf_window_ctrl #(.NrEvents(3), .CntWidth(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .sw_en_i(sw_en), .clear_i(clear),
    .vinsn_valid_i(vinsn), .ara_idle_i(idle), .event_i(ev),
    .state_o(s4), .runtime_o(rt4), .event_cnt_o(ec4),
    .snap_valid_o(sv4), .overflow_o(of4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sw_en = 1'b0; clear = 1'b0; vinsn = 1'b0; idle = 1'b1; ev = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Window with events; snapshot after Ara drains, software still enabled
    do_reset();
    for (int c = 0; c <= 33; c++) begin
      if (c == 0) begin
        chk("rst_state", 64'(s64), 64'd0);
        chk("rst_runtime", rt64, 64'd0);
        chk("rst_events", 64'(|ec64), 64'd0);
        chk("rst_snap", 64'(sv64), 64'd0);
        chk("rst_ovf", 64'(of64), 64'd0);
      end
      if (c == 10) chk("s1_idle_c10", 64'(s64), 64'd0);
      if (c == 11) chk("s1_run_c11", 64'(s64), 64'd1);
      if (c == 31) chk("s1_nosnap_c31", 64'(sv64), 64'd0);
      if (c == 32) begin
        chk("s1_snap_c32", 64'(sv64), 64'd1);
        chk("s1_runtime", rt64, 64'd20);
        chk("s1_ev0", ec64[0 +: 64], 64'd5);
        chk("s1_ev1", ec64[64 +: 64], 64'd0);
        chk("s1_ev2", ec64[128 +: 64], 64'd1);
        chk("s1_ovf", 64'(of64), 64'd0);
      end
      if (c == 33) begin
        chk("s1_snap_pulse_end", 64'(sv64), 64'd0);
        chk("s1_runtime_hold", rt64, 64'd20);
      end
      sw_en = 1'b1;
      vinsn = (c == 10);
      idle  = !(c >= 11 && c <= 30);
      ev    = {(c == 20), 1'b0, (c >= 15 && c <= 19)};
      tick();
    end
    // Asynchronous reset while the window is running
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 64'(s64), 64'd0);
    chk("async_rst_runtime", rt64, 64'd0);

    // Software disable mid-window, drain, then a late snapshot from IDLE
    do_reset();
    for (int c = 0; c <= 48; c++) begin
      if (c == 20) chk("s3_run_c20", 64'(s64), 64'd1);
      if (c == 21) chk("s3_drain_c21", 64'(s64), 64'd2);
      if (c == 40) chk("s3_drain_c40", 64'(s64), 64'd2);
      if (c == 41) begin
        chk("s3_idle_c41", 64'(s64), 64'd0);
        chk("s3_snap_c41", 64'(sv64), 64'd1);
        chk("s3_runtime_c41", rt64, 64'd29);
      end
      if (c == 46) chk("s3_nosnap_c46", 64'(sv64), 64'd0);
      if (c == 47) begin
        chk("s3_snap_c47", 64'(sv64), 64'd1);
        chk("s3_runtime_c47", rt64, 64'd30);
      end
      sw_en = (c < 20);
      vinsn = (c == 10) || (c == 45);
      idle  = (c >= 40) || (c < 10);
      ev    = '0;
      tick();
    end

    // Clear coincides with the snapshot condition (no reset: buffers hold 30)
    for (int c = 0; c <= 12; c++) begin
      if (c == 9) chk("s6_buf_hold", rt64, 64'd30);
      if (c == 11) begin
        chk("s6_clear_nosnap", 64'(sv64), 64'd0);
        chk("s6_clear_buf", rt64, 64'd0);
        chk("s6_state_idle", 64'(s64), 64'd0);
      end
      if (c == 12) chk("s6_flag_cleared", 64'(sv64), 64'd0);
      sw_en = (c < 8);
      vinsn = (c == 2);
      idle  = !(c >= 3 && c <= 9);
      clear = (c == 10);
      tick();
    end
    clear = 1'b0;

    // Request held while Ara idle: snapshot waits for the request to drop
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      if (c == 6 || c == 8 || c == 10) chk($sformatf("s4_nosnap_c%0d", c), 64'(sv64), 64'd0);
      if (c == 11) begin
        chk("s4_snap_c11", 64'(sv64), 64'd1);
        chk("s4_runtime", rt64, 64'd0);
        chk("s4_state", 64'(s64), 64'd0);
      end
      if (c == 12) chk("s4_snap_once", 64'(sv64), 64'd0);
      sw_en = 1'b0;
      idle  = 1'b1;
      vinsn = (c >= 5 && c <= 9);
      tick();
    end

    // Saturation on the 4-bit instance, then clear
    do_reset();
    for (int c = 0; c <= 32; c++) begin
      if (c == 18) chk("s5_ovf_c18", 64'(of4), 64'd0);
      if (c == 19) chk("s5_ovf_c19", 64'(of4), 64'd1);
      if (c == 27) begin
        chk("s5_snap4", 64'(sv4), 64'd1);
        chk("s5_rt4_sat", 64'(rt4), 64'd15);
        chk("s5_ev1_sat", 64'(ec4[7:4]), 64'd15);
        chk("s5_ovf_sticky", 64'(of4), 64'd1);
        chk("s5_rt64", rt64, 64'd23);
        chk("s5_ev1_64", ec64[64 +: 64], 64'd23);
        chk("s5_ovf64", 64'(of64), 64'd0);
      end
      if (c == 31) begin
        chk("s5_clr_rt4", 64'(rt4), 64'd0);
        chk("s5_clr_ec4", 64'(ec4), 64'd0);
        chk("s5_clr_ovf4", 64'(of4), 64'd0);
        chk("s5_clr_snap4", 64'(sv4), 64'd0);
      end
      sw_en = (c < 20);
      vinsn = (c == 2);
      idle  = !(c >= 3 && c <= 25);
      clear = (c == 30);
      ev    = 3'b010;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
